// File: rtl/adder_error_profiler.sv
// rtl/adder_error_profiler.sv - LFSR-driven error profiler for an external approximate adder
// Optional build macro ERRPROF_SATURATE_EN: err_count and sum_ed saturate instead of wrapping.
module adder_error_profiler #(
    parameter int          N      = 16,
    parameter int          CNT_W  = 32,
    parameter int          ACC_W  = 48,
    parameter logic [31:0] SEED_A = 32'hACE1_1234,
    parameter logic [31:0] SEED_B = 32'h1D87_5F0B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    input  logic [N-1:0]     approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [N-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic             v1_q, v1_d, v2_q, v2_d, drain_q, drain_d;
    logic [N-1:0]     ed_q, ed_d, max_ed_q, max_ed_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [N-1:0]     exact;
    logic             mismatch;
    logic [CNT_W:0]   err_ext;
    logic [ACC_W:0]   sum_ext;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        drain_d     = 1'b0;
        v1_d        = 1'b0;
        v2_d        = v1_q;

        // Stage 2: approx_sum belongs to the operands currently on op_a/op_b.
        exact = op_a_q + op_b_q;
        ed_d  = '0;
        if (v1_q) begin
            ed_d = (approx_sum >= exact) ? (approx_sum - exact) : (exact - approx_sum);
        end

        // Stage 3 accumulation with one extra bit to detect overflow.
        mismatch = v2_q && (ed_q != '0);
        err_ext  = {1'b0, err_count_q} + (CNT_W + 1)'(mismatch);
        sum_ext  = {1'b0, sum_ed_q} + ((ACC_W + 1)'(v2_q ? ed_q : '0));
`ifdef ERRPROF_SATURATE_EN
        err_count_d = err_ext[CNT_W] ? '1 : err_ext[CNT_W-1:0];
        sum_ed_d    = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
        err_count_d = err_ext[CNT_W-1:0];
        sum_ed_d    = sum_ext[ACC_W-1:0];
`endif
        max_ed_d = (v2_q && (ed_q > max_ed_q)) ? ed_q : max_ed_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = num_samples;
                    lfsr_a_d    = SEED_A;
                    lfsr_b_d    = SEED_B;
                    err_count_d = '0;
                    sum_ed_d    = '0;
                    max_ed_d    = '0;
                    state_d     = (num_samples == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (remaining_q != '0) begin
                    op_a_d      = lfsr_a_q[N-1:0];
                    op_b_d      = lfsr_b_q[N-1:0];
                    v1_d        = 1'b1;
                    lfsr_a_d    = lfsr_step(lfsr_a_q);
                    lfsr_b_d    = lfsr_step(lfsr_b_q);
                    remaining_d = remaining_q - CNT_W'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = !drain_q;
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            lfsr_a_q    <= SEED_A;
            lfsr_b_q    <= SEED_B;
            op_a_q      <= '0;
            op_b_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            drain_q     <= 1'b0;
            ed_q        <= '0;
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            drain_q     <= drain_d;
            ed_q        <= ed_d;
            err_count_q <= err_count_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err_count = err_count_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;

endmodule

// File: tb/tb_adder_error_profiler.sv
// tb/tb_adder_error_profiler.sv - randomized bench with a behavioural error-statistics model
module tb_adder_error_profiler;

    localparam logic [31:0] SEED_A = 32'hACE1_1234;
    localparam logic [31:0] SEED_B = 32'h1D87_5F0B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] num_samples;
    logic [15:0] op_a, op_b, approx_sum, max_ed;
    logic        busy, done;
    logic [31:0] err_count;
    logic [47:0] sum_ed;
    logic [15:0] op2_a, op2_b, approx2, err2, sum2, max2;
    logic        busy2, done2;
    int          cur_mode;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_err, exp_sum, exp_max, exp2_err, exp2_sum, exp2_max;

    always #5 clk = ~clk;

    adder_error_profiler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum), .busy(busy), .done(done),
        .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
    );

    adder_error_profiler #(.N(16), .CNT_W(16), .ACC_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples[15:0]),
        .op_a(op2_a), .op_b(op2_b), .approx_sum(approx2), .busy(busy2), .done(done2),
        .err_count(err2), .sum_ed(sum2), .max_ed(max2)
    );

    // Adders under test: pure functions of the operands.
    function automatic logic [15:0] approx_fn(int mode, logic [15:0] a, logic [15:0] b);
        logic [15:0] e;
        e = a + b;
        case (mode)
            0: return e;
            1: return e + 16'd1;
            2: return {a[15:10] + b[15:10] + {5'd0, (a[9] & b[9])}, a[9:0] | b[9:0]};
            3: return ~e;
            4: return e ^ {a[15:12] & b[15:12], 12'h000};
            default: return e - {13'd0, a[2:0]};
        endcase
    endfunction

    always_comb approx_sum = approx_fn(cur_mode, op_a, op_b);
    always_comb approx2    = ~(op2_a + op2_b);

    function automatic logic [31:0] lfsr_next(logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic logic [63:0] fit(logic [63:0] v, int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
`ifdef ERRPROF_SATURATE_EN
        return (v > mask) ? mask : v;
`else
        return v & mask;
`endif
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model(int mode, int m);
        logic [31:0] la, lb;
        logic [15:0] a, b, e, ap, ed, ed2;
        logic [63:0] err, sum, mx, s2, m2;
        la = SEED_A; lb = SEED_B;
        err = 0; sum = 0; mx = 0; s2 = 0; m2 = 0;
        for (int i = 0; i < m; i++) begin
            a = la[15:0]; b = lb[15:0]; e = a + b;
            ap  = approx_fn(mode, a, b);
            ed  = (ap > e) ? ap - e : e - ap;
            ed2 = ((~e) > e) ? (~e) - e : e - (~e);
            if (ed != 0) err++;
            sum += 64'(ed);
            if (64'(ed) > mx) mx = 64'(ed);
            s2 += 64'(ed2);
            if (64'(ed2) > m2) m2 = 64'(ed2);
            la = lfsr_next(la); lb = lfsr_next(lb);
        end
        exp_err  = fit(err, 32);
        exp_sum  = fit(sum, 48);
        exp_max  = mx;
        exp2_err = fit(64'(m), 16);
        exp2_sum = fit(s2, 16);
        exp2_max = m2;
    endtask

    // One run; every cycle from acceptance to two cycles past done is compared.
    task automatic run(int mode, int m, int glitch);
        logic [31:0] la, lb;
        int d;
        model(mode, m);
        cur_mode = mode;
        d = (m == 0) ? 3 : m + 4;
        la = SEED_A; lb = SEED_B;
        @(negedge clk);
        start = 1'b1; num_samples = 32'(m);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= d + 2; c++) begin
            check("busy", 64'(busy), 64'(c < d));
            check("done", 64'(done), 64'(c == d));
            if (c >= 2 && c <= m + 1) begin
                check("op_a", 64'(op_a), 64'(la[15:0]));
                check("op_b", 64'(op_b), 64'(lb[15:0]));
                la = lfsr_next(la); lb = lfsr_next(lb);
            end
            if (c == 2 && m >= 1) check("first_pair", {32'(op_a), 32'(op_b)}, {32'h1234, 32'h5F0B});
            if (c == 3 && m >= 2) check("second_pair", {32'(op_a), 32'(op_b)}, {32'h891A, 32'hAF86});
            if (c == 1) check("cleared", {16'(err_count), sum_ed}, 64'd0);
            if (c >= d) begin
                check("err_count", 64'(err_count), exp_err);
                check("sum_ed", 64'(sum_ed), exp_sum);
                check("max_ed", 64'(max_ed), exp_max);
            end
            if (c == d) begin
                check("done2", 64'(done2), 64'd1);
                check("err2", 64'(err2), exp2_err);
                check("sum2", 64'(sum2), exp2_sum);
                check("max2", 64'(max2), exp2_max);
            end
            start = (c == glitch);
            num_samples = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic reset_mid_run();
        cur_mode = 2;
        @(negedge clk);
        start = 1'b1; num_samples = 32'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stats", {16'(err_count), sum_ed}, 64'd0);
        check("rst_max_ops", {16'(max_ed), op_a, op_b}, 64'd0);
        check("rst_sum2", 64'(sum2), 64'd0);
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("post_rst_idle", {62'd0, busy, done}, 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int m, g, mode;
        rst_n = 1'b0; start = 1'b0; num_samples = '0; cur_mode = 0;
        repeat (3) @(negedge clk);
        check("reset_ops", {32'(op_a), 32'(op_b)}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        check("reset_stats", {16'(err_count), sum_ed}, 64'd0);
        check("reset_max", 64'(max_ed), 64'd0);
        rst_n = 1'b1;

        run(0, 0, 0);
        check("zero_run_stats", {16'(err_count), sum_ed}, 64'd0);
        run(0, 1000, 0);
        check("exact_err", 64'(err_count), 64'd0);
        check("exact_max", 64'(max_ed), 64'd0);
        run(1, 100, 0);
        check("obo_err", 64'(err_count), 64'd100);
        check("obo_sum", 64'(sum_ed), 64'd100);
        check("obo_max", 64'(max_ed), 64'd1);
        run(3, 300, 0);
`ifdef ERRPROF_SATURATE_EN
        check("acc16_sat", 64'(sum2), 64'hFFFF);
`else
        check("acc16_wrap", 64'(sum2), 64'(sum_ed[15:0]));
`endif
        run(2, 10000, 0);
        run(4, 150, 7);
        reset_mid_run();
        run(2, 200, 0);
        for (int i = 0; i < 8; i++) begin
            mode = $urandom_range(0, 5);
            m = $urandom_range(0, 400);
            g = $urandom_range(0, 1) ? $urandom_range(1, (m == 0) ? 3 : m + 4) : 0;
            run(mode, m, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
